// File: rtl/comp_sgpr_pkg.sv
// Shared widths and word type for the comparing, fault-tolerant GPR file.
// Imported by the register file and by the comparing wrapper.
package comp_sgpr_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS_DEF   = 2 ** ADDR_WIDTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/sgpr_regfile.sv
// Register file: one write port, two combinational read ports, async clear.
// Register 0 has no storage and always reads as zero.
module sgpr_regfile
    import comp_sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] words;

    assign words[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] q;
        logic                  hit;

        assign hit = we && (waddr == ADDR_WIDTH'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (hit) begin
                q <= wdata;
            end
        end

        assign words[i] = q;
    end

    // Reads see the stored value only, so a same-cycle write is not bypassed.
    assign rdata_a = words[raddr_a];
    assign rdata_b = words[raddr_b];

endmodule

// File: rtl/comp_sgpr.sv
// Dual-source comparing GPR file: a write lands only when both sources agree,
// and any disagreement raises the combinational mismatch flag.
module comp_sgpr
    import comp_sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic                  signal
);

    logic en_equal;
    logic addr_equal;
    logic data_equal;
    logic both_on;
    logic match;
    logic wr_en;

    assign en_equal   = (we_a_i == we_b_i);
    assign addr_equal = (addr_a_i == addr_b_i);
    assign data_equal = (data_a_i == data_b_i);
    assign both_on    = we_a_i & we_b_i;

    // Address/data only matter when both sources actually intend a write.
    assign match  = en_equal & (~both_on | (addr_equal & data_equal));
    assign signal = ~match;
    assign wr_en  = match & we_a_i;

    sgpr_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .waddr  (addr_a_i),
        .wdata  (data_a_i),
        .raddr_a(raddr_a_i),
        .rdata_a(rdata_a_o),
        .raddr_b(raddr_b_i),
        .rdata_b(rdata_b_o)
    );

endmodule

// File: tb/tb_comp_sgpr.sv
// Bench for comp_sgpr: directed vectors, a behavioural register model
// checked every negedge, and literal expectations pinning the model.
module tb_comp_sgpr;
    import comp_sgpr_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     we_a_i, we_b_i;
    reg_idx_t addr_a_i, addr_b_i;
    word_t    data_a_i, data_b_i;
    reg_idx_t raddr_a_i, raddr_b_i;
    word_t    rdata_a_o, rdata_b_o;
    logic     signal;

    int total = 0;
    int bad = 0;
    bit running = 0;
    word_t model [NUM_REGS_DEF];

    comp_sgpr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_a_i   (we_a_i),
        .we_b_i   (we_b_i),
        .addr_a_i (addr_a_i),
        .addr_b_i (addr_b_i),
        .data_a_i (data_a_i),
        .data_b_i (data_b_i),
        .raddr_a_i(raddr_a_i),
        .rdata_a_o(rdata_a_o),
        .raddr_b_i(raddr_b_i),
        .rdata_b_o(rdata_b_o),
        .signal   (signal)
    );

    always #5 clk = ~clk;

    function automatic logic mism();
        if (we_a_i !== we_b_i) return 1'b1;
        if (we_a_i && (addr_a_i !== addr_b_i || data_a_i !== data_b_i))
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS_DEF; i++) model[i] = '0;
        end else if (!mism() && we_a_i && addr_a_i != 0) begin
            model[addr_a_i] = data_a_i;
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("model_rdata_a", rdata_a_o, model[raddr_a_i]);
            chk("model_rdata_b", rdata_b_o, model[raddr_b_i]);
            chk("model_signal", word_t'(signal), word_t'(mism()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wa, input logic wb,
                         input int aa, input int ab,
                         input int da, input int db);
        we_a_i   = wa;
        we_b_i   = wb;
        addr_a_i = reg_idx_t'(aa);
        addr_b_i = reg_idx_t'(ab);
        data_a_i = word_t'(da);
        data_b_i = word_t'(db);
    endtask

    task automatic rd(input int a, input int b);
        raddr_a_i = reg_idx_t'(a);
        raddr_b_i = reg_idx_t'(b);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS_DEF; i++) model[i] = '0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rd(10, 10);
        repeat (2) step();
        chk("reset_rdata_a", rdata_a_o, 0);
        chk("reset_signal", word_t'(signal), 0);
        rst_n = 1'b1;
        running = 1;
        step();

        chk("r10_init_a", rdata_a_o, 0);
        chk("r10_init_b", rdata_b_o, 0);
        chk("r10_init_sig", word_t'(signal), 0);

        drive(1, 1, 10, 10, 100, 100);
        #1;
        chk("r10_pre_edge_a", rdata_a_o, 0);
        chk("r10_pre_edge_b", rdata_b_o, 0);
        chk("r10_write_sig", word_t'(signal), 0);
        step();
        chk("r10_post_a", rdata_a_o, 100);
        chk("r10_post_b", rdata_b_o, 100);

        drive(1, 1, 11, 11, 100, 100);
        rd(11, 10);
        step();
        chk("r11_a", rdata_a_o, 100);
        chk("r10_b", rdata_b_o, 100);

        drive(1, 1, 11, 10, 55, 55);
        #1;
        chk("addr_diff_sig", word_t'(signal), 1);
        step();
        chk("addr_diff_r11", rdata_a_o, 100);
        chk("addr_diff_r10", rdata_b_o, 100);

        drive(1, 1, 12, 12, 7, 8);
        rd(12, 12);
        #1;
        chk("data_diff_sig", word_t'(signal), 1);
        step();
        chk("data_diff_r12", rdata_a_o, 0);

        drive(1, 0, 12, 12, 7, 7);
        #1;
        chk("we_diff_sig", word_t'(signal), 1);
        step();
        chk("we_diff_r12", rdata_b_o, 0);

        drive(0, 0, 3, 9, 1234, 99);
        #1;
        chk("idle_diff_sig", word_t'(signal), 0);
        step();

        drive(1, 1, 0, 0, 100, 100);
        rd(0, 0);
        #1;
        chk("r0_write_sig", word_t'(signal), 0);
        step();
        chk("r0_read_a", rdata_a_o, 0);
        chk("r0_read_b", rdata_b_o, 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 31 - i, 31 - i, 32'h1000 + i * 17, 32'h1000 + i * 17);
            rd(31 - i, 24 + (i % 4));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        rd(31, 24);
        #1;
        chk("r31_a", rdata_a_o, 32'h1000);
        chk("r24_b", rdata_b_o, 32'h1000 + 7 * 17);

        drive(1, 1, 5, 5, -1, -1);
        rd(10, 11);
        step();
        drive(1, 0, 5, 5, 3, 3);
        rd(10, 5);
        #1;
        chk("pre_reset_r5", rdata_b_o, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("async_clr_a", rdata_a_o, 0);
        chk("async_clr_b", rdata_b_o, 0);
        chk("reset_sig_valid", word_t'(signal), 1);
        step();
        drive(1, 1, 7, 7, 9, 9);
        step();
        chk("reset_no_write", rdata_a_o, 0);
        rst_n = 1'b1;
        rd(7, 10);
        step();
        chk("release_write_r7", rdata_a_o, 9);
        chk("release_r10", rdata_b_o, 0);

        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
